// File: rtl/dst_act_fifo.sv
// Activation output FIFO between core dst stream and host DMA; words are IEEE-754 doubles.
// Optional ReLU on write is enabled by defining DST_RELU_EN.
module dst_act_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   relu,
  input  logic                   in_valid,
  input  logic [63:0]            in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [63:0]            out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW-1:0]          pkt_cnt,
  output logic [CW-1:0]          word_cnt,
  output logic                   in_pkt_open
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [64:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_pkt;
  logic [CW-1:0] r_word;
  logic          r_open;
  logic          r_rdy;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [63:0]   w_wdata;
  logic [64:0]   w_head;

  assign w_empty   = (r_level == '0);
  assign in_ready  = r_rdy & (r_level != FULL) & ~flush;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready & ~flush;
  assign w_head    = r_mem[r_rd];

  // Gated so an empty or freshly reset FIFO shows zero, not stale RAM
  assign out_data  = w_empty ? '0 : w_head[63:0];
  assign out_last  = w_empty ? 1'b0 : w_head[64];

  assign level       = r_level;
  assign pkt_cnt     = r_pkt;
  assign word_cnt    = r_word;
  assign in_pkt_open = r_open;

`ifdef DST_RELU_EN
  logic w_nan;
  logic w_neg;

  // -0.0 and NaN do not compare below 0.0, so they pass unchanged
  assign w_nan = (&in_data[62:52]) & (|in_data[51:0]);
  assign w_neg = in_data[63] & (|in_data[62:0]) & ~w_nan;

  always_comb begin
    w_wdata = in_data;
    if (relu & w_neg) w_wdata = '0;
  end
`else
  logic w_unused_relu;

  assign w_unused_relu = relu;

  always_comb begin
    w_wdata = in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {in_last, w_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt  <= '0;
      r_word <= '0;
    end else if (flush) begin
      r_word <= '0;
    end else if (w_pop) begin
      if (out_last) begin
        r_pkt  <= r_pkt + CW'(1);
        r_word <= '0;
      end else begin
        r_word <= r_word + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= 1'b0;
    end else if (flush) begin
      r_open <= 1'b0;
    end else if (w_push) begin
      r_open <= ~in_last;
    end
  end

endmodule

// File: doc/dst_act_fifo.md
DST_ACT_FIFO -- requirements
Module: dst_act_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter CW, default 16, packet/word counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of FIFO contents and word count.
REQ-006 SHALL have port relu  input  1  apply ReLU to words on write (only with DST_RELU_EN).
REQ-007 SHALL have ports in_valid / in_data / in_last  input  1 / real / 1  upstream stream, driven by the core's dst_valid/dst_data/dst_last.
REQ-008 SHALL have port in_ready  output  1  upstream backpressure, drives the core's dst_ready.
REQ-009 SHALL have ports out_valid / out_data / out_last  output  1 / real / 1  downstream stream to host DMA.
REQ-010 SHALL have port out_ready  input  1  downstream backpressure.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port pkt_cnt  output  CW  completed output packets.
REQ-013 SHALL have port word_cnt  output  CW  words sent in the current packet.
REQ-014 SHALL have port in_pkt_open  output  1  an accepted input packet has not yet seen in_last.

Function
REQ-015 SHALL accept a word when in_valid & in_ready; SHALL pop when out_valid & out_ready.
REQ-016 SHALL drive in_ready = (level < DEPTH) & ~flush; full with a simultaneous pop SHALL NOT accept (no pass-through).
REQ-017 SHALL drive out_valid = (level != 0); out_data/out_last SHALL present the head entry (first-word-fall-through).
REQ-018 SHALL show a word written in cycle N on out_valid in cycle N+1 at the earliest; no combinational in-to-out path.
REQ-019 SHALL keep level unchanged on simultaneous push and pop; level SHALL never exceed DEPTH nor underflow.
REQ-020 SHALL wrap read/write pointers modulo DEPTH.
REQ-021 SHALL hold out_data/out_last stable while out_valid & ~out_ready.
REQ-022 SHALL increment word_cnt per pop without out_last; a pop with out_last SHALL clear word_cnt and increment pkt_cnt.
REQ-023 SHALL wrap pkt_cnt and word_cnt from 2^CW-1 to 0 silently.
REQ-024 SHALL set in_pkt_open on an accepted word without in_last, clear it on an accepted word with in_last.
REQ-025 flush SHALL, next edge, set level=0, word_cnt=0, in_pkt_open=0, discard any same-cycle push/pop; pkt_cnt SHALL be preserved.
REQ-026 SHALL store in_last alongside each data word.

Reset
REQ-027 rst_n low SHALL immediately force level=0, pointers=0, pkt_cnt=0, word_cnt=0, in_pkt_open=0, out_valid=0, out_last=0, out_data=0.0.
REQ-028 in_ready SHALL be 0 while rst_n low and 1 from the first edge after deassertion.
REQ-029 reset mid-packet SHALL drop all stored words; no partial packet SHALL emerge afterwards.

Configuration
REQ-030 Macro DST_RELU_EN defined: written word = (relu & in_data < 0.0) ? 0.0 : in_data.
REQ-031 Macro DST_RELU_EN undefined: relu SHALL be ignored; data stored unmodified; port still present.

Verification
REQ-032 Push 3 words (1.5, -2.0, 4.0 last), out_ready=1 -> out 1.5, -2.0, 4.0 from cycle after first push; pkt_cnt=1, word_cnt=0.
REQ-033 out_ready=0, push 10 words, DEPTH=8 -> in_ready low after 8th, level=8; raise out_ready -> all 10 delivered in order.
REQ-034 Full FIFO, in_valid=1, out_ready=1 same cycle -> one pop, no push, level=7; push accepted next cycle.
REQ-035 DST_RELU_EN, relu=1, push -3.25, 0.0, 2.5 -> out 0.0, 0.0, 2.5; relu=0 -> -3.25 passes.
REQ-036 Push 5 words no last, flush at level 5 -> level=0, out_valid=0, in_pkt_open=0, pkt_cnt unchanged.
REQ-037 rst_n low mid-stream with level 4 -> outputs zero immediately; after release first pushed word is first out.
